// File: rtl/minibyte_bus_ctrl_if.sv
// Signal bundle for the Minibyte bus controller: CPU handshake, demo-ROM port and chip-level bus pins.
// slave is the controller's own view; master is the view of the CPU/ROM/pad logic around it.
interface minibyte_bus_ctrl_if #(
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 8,
   parameter int ROM_ADDR_W = 5
);
   logic                  cpu_req_in;
   logic                  cpu_we_in;
   logic [ADDR_W-1:0]     cpu_addr_in;
   logic [DATA_W-1:0]     cpu_wdata_in;
   logic [DATA_W-1:0]     cpu_rdata_out;
   logic                  cpu_ready_out;
   logic                  cpu_err_out;
   logic                  rom_sel_in;
   logic [ROM_ADDR_W-1:0] rom_addr_out;
   logic [DATA_W-1:0]     rom_data_in;
   logic                  ext_ready_in;
   logic [ADDR_W-1:0]     bus_addr_out;
   logic                  bus_we_out;
   logic [DATA_W-1:0]     bus_data_in;
   logic [DATA_W-1:0]     bus_data_out;
   logic [DATA_W-1:0]     bus_oe_out;

   modport slave (
      input  cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
      input  rom_sel_in, rom_data_in, ext_ready_in, bus_data_in,
      output cpu_rdata_out, cpu_ready_out, cpu_err_out, rom_addr_out,
      output bus_addr_out, bus_we_out, bus_data_out, bus_oe_out
   );

   modport master (
      output cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
      output rom_sel_in, rom_data_in, ext_ready_in, bus_data_in,
      input  cpu_rdata_out, cpu_ready_out, cpu_err_out, rom_addr_out,
      input  bus_addr_out, bus_we_out, bus_data_out, bus_oe_out
   );
endinterface

// File: rtl/minibyte_bus_ctrl.sv
// Sequenced memory/IO bus controller for the Minibyte core: setup, wait states, ready/timeout, ROM redirect.
// Define MINIBYTE_BUS_TURNAROUND_EN to add a bus-release TURN cycle after every external write.
module minibyte_bus_ctrl #(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int ROM_ADDR_W  = 5,
   parameter int WAIT_CYCLES = 1,
   parameter int TIMEOUT     = 255
) (
   input  logic               clk_in,
   input  logic               rst_in,
   minibyte_bus_ctrl_if.slave io
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_WAIT,
      S_STROBE,
`ifdef MINIBYTE_BUS_TURNAROUND_EN
      S_DONE,
      S_TURN
`else
      S_DONE
`endif
   } state_t;

   state_t            state;
   state_t            next_state;

   logic [ADDR_W-1:0] lat_addr;
   logic              lat_we;
   logic              lat_rom;
   logic [3:0]        wait_cnt;
   logic [7:0]        to_cnt;

   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] oe_q;
   logic              ready_q;
   logic              err_q;
   logic              we_q;

   logic              accept;
   logic              rom_read;
   logic              timeout_hit;
   logic              eff_we;

   logic              ready_d;
   logic              err_d;
   logic              we_d;
   logic              oe_d;
   logic              rdata_load;
   logic [DATA_W-1:0] rdata_d;

   assign accept      = (state == S_IDLE) && io.cpu_req_in;
   assign rom_read    = lat_rom && !lat_we;
   assign timeout_hit = (state == S_STROBE) && !io.ext_ready_in && (to_cnt == 8'(TIMEOUT - 1));
   // The access being set up on this edge uses the live CPU inputs, later cycles the latched copy.
   assign eff_we      = accept ? io.cpu_we_in : lat_we;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (io.cpu_req_in) next_state = S_SETUP;
         S_SETUP: begin
            if (rom_read)             next_state = S_DONE;
            else if (WAIT_CYCLES > 0) next_state = S_WAIT;
            else                      next_state = S_STROBE;
         end
         S_WAIT:   if (wait_cnt <= 4'd1) next_state = S_STROBE;
         S_STROBE: if (io.ext_ready_in || timeout_hit) next_state = S_DONE;
`ifdef MINIBYTE_BUS_TURNAROUND_EN
         S_DONE:   next_state = lat_we ? S_TURN : S_IDLE;
         S_TURN:   next_state = S_IDLE;
`else
         S_DONE:   next_state = S_IDLE;
`endif
         default:  next_state = S_IDLE;
      endcase
   end

   // Output values are computed for the state being entered so the registered pins line up with it.
   always_comb begin
      ready_d    = (next_state == S_DONE);
      err_d      = (next_state == S_DONE) && timeout_hit;
      we_d       = (next_state == S_STROBE) && lat_we;
      oe_d       = eff_we && (next_state inside {S_SETUP, S_WAIT, S_STROBE, S_DONE});
      rdata_load = 1'b0;
      rdata_d    = '0;
      if ((state == S_SETUP) && rom_read) begin
         rdata_load = 1'b1;
         rdata_d    = io.rom_data_in;
      end else if (timeout_hit) begin
         rdata_load = 1'b1;
         rdata_d    = '1;
      end else if ((state == S_STROBE) && io.ext_ready_in && !lat_we) begin
         rdata_load = 1'b1;
         rdata_d    = io.bus_data_in;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         lat_addr <= '0;
         lat_we   <= 1'b0;
         lat_rom  <= 1'b0;
         wait_cnt <= '0;
         to_cnt   <= '0;
         rdata_q  <= '0;
         wdata_q  <= '0;
         oe_q     <= '0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
         we_q     <= 1'b0;
      end else begin
         ready_q <= ready_d;
         err_q   <= err_d;
         we_q    <= we_d;
         oe_q    <= {DATA_W{oe_d}};
         if (rdata_load) rdata_q <= rdata_d;
         if (accept) begin
            lat_addr <= io.cpu_addr_in;
            lat_we   <= io.cpu_we_in;
            lat_rom  <= io.rom_sel_in;
            if (io.cpu_we_in) wdata_q <= io.cpu_wdata_in;
         end
         if (state == S_SETUP)     wait_cnt <= 4'(WAIT_CYCLES);
         else if (state == S_WAIT) wait_cnt <= wait_cnt - 4'd1;
         if (state != S_STROBE)    to_cnt <= '0;
         else if (!io.ext_ready_in) to_cnt <= to_cnt + 8'd1;
      end
   end

   assign io.cpu_rdata_out = rdata_q;
   assign io.cpu_ready_out = ready_q;
   assign io.cpu_err_out   = err_q;
   assign io.rom_addr_out  = lat_addr[ROM_ADDR_W-1:0];
   assign io.bus_addr_out  = lat_addr;
   assign io.bus_we_out    = we_q;
   assign io.bus_data_out  = wdata_q;
   assign io.bus_oe_out    = oe_q;

endmodule

// File: tb/tb_minibyte_bus_ctrl.sv
// Self-checking bench for minibyte_bus_ctrl (WAIT_CYCLES=1, TIMEOUT=4): cycle table plus corner-case sequences.
// Expectations for the write-then-read gap follow MINIBYTE_BUS_TURNAROUND_EN when it is defined.
module tb_minibyte_bus_ctrl;

   localparam int ADDR_W      = 7;
   localparam int DATA_W      = 8;
   localparam int ROM_ADDR_W  = 5;
   localparam int WAIT_CYCLES = 1;
   localparam int TIMEOUT     = 4;
`ifdef MINIBYTE_BUS_TURNAROUND_EN
   localparam int TURN_GAP = 1;
`else
   localparam int TURN_GAP = 0;
`endif

   typedef struct {
      logic       req;
      logic       we;
      logic [6:0] addr;
      logic [7:0] wdata;
      logic       rom_sel;
      logic       ext_ready;
      logic [7:0] bdata;
      logic       exp_ready;
      logic       exp_err;
      logic       exp_we;
      logic [7:0] exp_rdata;
      logic [7:0] exp_oe;
      logic [6:0] exp_addr;
      logic [7:0] exp_dout;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;
   vec_t vecs[$];

   minibyte_bus_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_ADDR_W(ROM_ADDR_W)) bif ();

   minibyte_bus_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_ADDR_W(ROM_ADDR_W),
      .WAIT_CYCLES(WAIT_CYCLES), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_in(clk),
      .rst_in(rst),
      .io(bif)
   );

   always #5 clk = ~clk;

   // Demo ROM contents: byte a = 0x40 + 3*a (byte 3 = 0x49, byte 5 = 0x4F).
   function automatic logic [7:0] rom_byte(input logic [4:0] a);
      return 8'h40 + 8'(a) * 8'd3;
   endfunction

   always_comb bif.rom_data_in = rom_byte(bif.rom_addr_out);

   function automatic vec_t mk(input logic req, input logic we, input logic [6:0] addr,
                               input logic [7:0] wdata, input logic rom_sel, input logic ext_ready,
                               input logic [7:0] bdata, input logic exp_ready, input logic exp_err,
                               input logic exp_we, input logic [7:0] exp_rdata, input logic [7:0] exp_oe,
                               input logic [6:0] exp_addr, input logic [7:0] exp_dout);
      vec_t v;
      v.req = req; v.we = we; v.addr = addr; v.wdata = wdata; v.rom_sel = rom_sel;
      v.ext_ready = ext_ready; v.bdata = bdata; v.exp_ready = exp_ready; v.exp_err = exp_err;
      v.exp_we = exp_we; v.exp_rdata = exp_rdata; v.exp_oe = exp_oe; v.exp_addr = exp_addr;
      v.exp_dout = exp_dout;
      return v;
   endfunction

   task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bif.cpu_req_in   = v.req;
      bif.cpu_we_in    = v.we;
      bif.cpu_addr_in  = v.addr;
      bif.cpu_wdata_in = v.wdata;
      bif.rom_sel_in   = v.rom_sel;
      bif.ext_ready_in = v.ext_ready;
      bif.bus_data_in  = v.bdata;
   endtask

   task automatic checkOutput(input vec_t v, input string tag);
      compareField({tag, " ready"},    32'(bif.cpu_ready_out), 32'(v.exp_ready));
      compareField({tag, " err"},      32'(bif.cpu_err_out),   32'(v.exp_err));
      compareField({tag, " rdata"},    32'(bif.cpu_rdata_out), 32'(v.exp_rdata));
      compareField({tag, " bus_we"},   32'(bif.bus_we_out),    32'(v.exp_we));
      compareField({tag, " bus_oe"},   32'(bif.bus_oe_out),    32'(v.exp_oe));
      compareField({tag, " bus_addr"}, 32'(bif.bus_addr_out),  32'(v.exp_addr));
      compareField({tag, " bus_dout"}, 32'(bif.bus_data_out),  32'(v.exp_dout));
      compareField({tag, " rom_addr"}, 32'(bif.rom_addr_out),  32'(v.exp_addr[4:0]));
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Called just after the edge that starts cycle 0; returns at the falling edge of the ready cycle.
   task automatic runUntilReady(input int bound, output int cyc);
      cyc = 0;
      @(negedge clk);
      while (bif.cpu_ready_out !== 1'b1 && cyc < bound) begin
         @(negedge clk);
         cyc++;
      end
      if (bif.cpu_ready_out !== 1'b1) begin
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL ready wait: no ready pulse within %0d cycles, required one", bound);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cyc;
      int pulses;
      bit found;

      applyStimulus(mk(0, 0, 7'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 7'h00, 8'h00));
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput(mk(0, 0, 7'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 7'h00, 8'h00), "reset");
      nextCycle();
      rst = 1'b0;

      //          req we addr   wdata  rom ext bdata  rdy err we rdata  oe     addr   dout
      // ROM read of 0x25: ready in cycle 2 with ROM byte 5
      vecs.push_back(mk(1, 0, 7'h25, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 7'h00, 8'h00));
      vecs.push_back(mk(1, 0, 7'h25, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 7'h25, 8'h00));
      vecs.push_back(mk(1, 0, 7'h25, 8'h00, 1, 0, 8'h00, 1, 0, 0, 8'h4F, 8'h00, 7'h25, 8'h00));
      vecs.push_back(mk(0, 0, 7'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h4F, 8'h00, 7'h25, 8'h00));
      // External write 0xA5 to 0x7F with rom_sel high: strobe in cycle 3, ready in cycle 4
      vecs.push_back(mk(1, 1, 7'h7F, 8'hA5, 1, 1, 8'h00, 0, 0, 0, 8'h4F, 8'h00, 7'h25, 8'h00));
      vecs.push_back(mk(1, 1, 7'h7F, 8'hA5, 1, 1, 8'h00, 0, 0, 0, 8'h4F, 8'hFF, 7'h7F, 8'hA5));
      vecs.push_back(mk(1, 1, 7'h7F, 8'hA5, 1, 1, 8'h00, 0, 0, 0, 8'h4F, 8'hFF, 7'h7F, 8'hA5));
      vecs.push_back(mk(1, 1, 7'h7F, 8'hA5, 1, 1, 8'h00, 0, 0, 1, 8'h4F, 8'hFF, 7'h7F, 8'hA5));
      vecs.push_back(mk(1, 1, 7'h7F, 8'hA5, 1, 1, 8'h00, 1, 0, 0, 8'h4F, 8'hFF, 7'h7F, 8'hA5));
      vecs.push_back(mk(0, 0, 7'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h4F, 8'h00, 7'h7F, 8'hA5));
      vecs.push_back(mk(0, 0, 7'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h4F, 8'h00, 7'h7F, 8'hA5));
      // External read of 0x12: ready ignored in WAIT, low for 3 STROBE cycles, rom_sel toggled mid-access
      vecs.push_back(mk(1, 0, 7'h12, 8'h00, 0, 0, 8'h3C, 0, 0, 0, 8'h4F, 8'h00, 7'h7F, 8'hA5));
      vecs.push_back(mk(1, 0, 7'h12, 8'h00, 0, 0, 8'h3C, 0, 0, 0, 8'h4F, 8'h00, 7'h12, 8'hA5));
      vecs.push_back(mk(1, 0, 7'h12, 8'h00, 1, 1, 8'h3C, 0, 0, 0, 8'h4F, 8'h00, 7'h12, 8'hA5));
      vecs.push_back(mk(1, 0, 7'h12, 8'h00, 1, 0, 8'h3C, 0, 0, 0, 8'h4F, 8'h00, 7'h12, 8'hA5));
      vecs.push_back(mk(1, 0, 7'h12, 8'h00, 1, 0, 8'h3C, 0, 0, 0, 8'h4F, 8'h00, 7'h12, 8'hA5));
      vecs.push_back(mk(1, 0, 7'h12, 8'h00, 1, 0, 8'h3C, 0, 0, 0, 8'h4F, 8'h00, 7'h12, 8'hA5));
      vecs.push_back(mk(1, 0, 7'h12, 8'h00, 1, 1, 8'h3C, 0, 0, 0, 8'h4F, 8'h00, 7'h12, 8'hA5));
      vecs.push_back(mk(1, 0, 7'h12, 8'h00, 0, 0, 8'h3C, 1, 0, 0, 8'h3C, 8'h00, 7'h12, 8'hA5));
      vecs.push_back(mk(0, 0, 7'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h3C, 8'h00, 7'h12, 8'hA5));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput(vecs[i], $sformatf("vec%0d", i));
         nextCycle();
      end

      // Timeout: ready never arrives, so DONE with err in cycle WAIT_CYCLES+6
      applyStimulus(mk(1, 0, 7'h40, 8'h00, 0, 0, 8'h3C, 0, 0, 0, 8'h00, 8'h00, 7'h00, 8'h00));
      runUntilReady(20, cyc);
      compareField("timeout ready cycle", 32'(cyc), 32'(WAIT_CYCLES + 6));
      compareField("timeout err",   32'(bif.cpu_err_out),   32'h1);
      compareField("timeout rdata", 32'(bif.cpu_rdata_out), 32'hFF);
      bif.cpu_req_in = 1'b0;
      nextCycle();
      @(negedge clk);
      compareField("timeout err clears", 32'(bif.cpu_err_out),   32'h0);
      compareField("timeout rdata held", 32'(bif.cpu_rdata_out), 32'hFF);
      nextCycle();

      // Reset during WAIT of a write: everything clears, no ready, then a ROM read works
      applyStimulus(mk(1, 1, 7'h33, 8'h5A, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 7'h00, 8'h00));
      nextCycle();
      nextCycle();
      @(negedge clk);
      compareField("pre-reset bus_oe", 32'(bif.bus_oe_out), 32'hFF);
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      bif.cpu_req_in = 1'b0;
      @(negedge clk);
      checkOutput(mk(0, 0, 7'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 7'h00, 8'h00), "midreset");
      pulses = 0;
      repeat (4) begin
         nextCycle();
         @(negedge clk);
         if (bif.cpu_ready_out !== 1'b0) pulses++;
      end
      compareField("post-reset ready pulses", 32'(pulses), 32'h0);
      nextCycle();
      applyStimulus(mk(1, 0, 7'h03, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 7'h00, 8'h00));
      runUntilReady(10, cyc);
      compareField("post-reset rom ready cycle", 32'(cyc), 32'h2);
      compareField("post-reset rom rdata", 32'(bif.cpu_rdata_out), 32'h49);
      bif.cpu_req_in = 1'b0;
      nextCycle();

      // Write immediately followed by a read with req held high across DONE
      applyStimulus(mk(1, 1, 7'h01, 8'h77, 0, 1, 8'h3C, 0, 0, 0, 8'h00, 8'h00, 7'h00, 8'h00));
      runUntilReady(10, cyc);
      compareField("wr ready cycle", 32'(cyc), 32'h4);
      compareField("wr err", 32'(bif.cpu_err_out), 32'h0);
      bif.cpu_we_in   = 1'b0;
      bif.cpu_addr_in = 7'h02;
      nextCycle();
      @(negedge clk);
      compareField("wr->rd cycle5 bus_oe", 32'(bif.bus_oe_out),    32'h0);
      compareField("wr->rd cycle5 ready",  32'(bif.cpu_ready_out), 32'h0);
      cyc   = 5;
      found = 1'b0;
      while (!found && cyc < 12) begin
         if (bif.bus_addr_out === 7'h02) begin
            found = 1'b1;
         end else begin
            nextCycle();
            @(negedge clk);
            cyc++;
         end
      end
      compareField("wr->rd read setup cycle", 32'(cyc), 32'(6 + TURN_GAP));
      compareField("wr->rd read bus_oe", 32'(bif.bus_oe_out), 32'h0);
      nextCycle();
      runUntilReady(10, cyc);
      compareField("wr->rd read ready offset", 32'(cyc), 32'h2);
      compareField("wr->rd read rdata", 32'(bif.cpu_rdata_out), 32'h3C);
      bif.cpu_req_in = 1'b0;
      nextCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
